fpu_op_sequencer: RTL and testbench
===================================

// Module: fpu_op_sequencer
// PURPOSE
//  Initiator for fpu_16bit: queues half-precision add/sub/mul/div commands and issues them one at a time.
//  Holds opcode and operands stable, restarts the FPU, waits for done and returns result/OFUF over a valid/ready response port.
//  Sits between the command source (CPU/test master) and the FPU; adds an independent timeout guard.
// PARAMETERS
//  DEPTH    4   command FIFO entries (power of 2, >=2)
//  TIMEOUT  64  max WAIT cycles before forced timeout response (>=2)
// PORTS
//  clk          in   1   single clock, all logic on posedge
//  reset        in   1   synchronous, active-high
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   FIFO can accept; = !full (combinational from count)
//  cmd_opcode   in   2   0 add, 1 sub, 2 mul, 3 div
//  cmd_x        in   16  operand X, IEEE half
//  cmd_y        in   16  operand Y, IEEE half
//  rsp_valid    out  1   response held until accepted
//  rsp_ready    in   1   consumer accepts response
//  rsp_result   out  16  FPU result, or 16'h7E00 on timeout
//  rsp_ofuf     out  2   FPU OFUF, or 2'b00 on timeout
//  rsp_opcode   out  2   opcode of the answered command
//  rsp_timeout  out  1   1 = FPU never asserted done
//  fpu_opcode   out  2   to FPU opcode
//  fpu_x        out  16  to FPU X
//  fpu_y        out  16  to FPU Y
//  fpu_reset    out  1   to FPU reset; = reset | (state==LAUNCH)
//  fpu_done     in   1   from FPU done
//  fpu_result   in   16  from FPU result
//  fpu_ofuf     in   2   from FPU OFUF
// BEHAVIOUR
//  Reset (sync): FIFO flushed (count=0), state IDLE, rsp_valid=0, rsp_result=0, rsp_ofuf=0, rsp_opcode=0,
//   rsp_timeout=0, fpu_opcode=0, fpu_x=0, fpu_y=0, wait counter=0; fpu_reset=1 while reset high. Reset mid-op drops in-flight command and response.
//  FIFO: 34-bit entries {opcode,x,y}; push on cmd_valid&cmd_ready; pop only in IDLE when non-empty.
//   Simultaneous push+pop: both occur, count unchanged. Full: cmd_ready=0, no push even if popping that cycle. Pointers wrap mod DEPTH.
//  FSM:
//   IDLE   : if FIFO non-empty -> pop head into fpu_opcode/fpu_x/fpu_y, -> LAUNCH; else stay.
//   LAUNCH : fpu_reset=1 exactly one cycle; counter cleared; -> WAIT.
//   WAIT   : counter++ each cycle; fpu_done sampled every WAIT cycle (never in LAUNCH, so stale done ignored).
//            fpu_done=1 -> capture fpu_result/fpu_ofuf, rsp_timeout=0 -> RESP.
//            else counter==TIMEOUT-1 -> rsp_result=16'h7E00, rsp_ofuf=0, rsp_timeout=1 -> RESP.
//            done and timeout same cycle: done wins.
//   RESP   : rsp_valid=1, rsp_* stable; on rsp_ready -> rsp_valid=0 next cycle, -> IDLE.
//  fpu_opcode/x/y stable from LAUNCH through RESP; change only on IDLE pop.
//  Latency: push at T into empty FIFO -> pop T+1, LAUNCH T+2, WAIT from T+3; done sampled at cycle N -> rsp_valid at N+1.
//   Back-to-back: rsp handshake at R -> IDLE R+1 -> next LAUNCH R+2.
//  One command in flight; responses in command order. FIFO keeps accepting while busy.
// TESTING
//  1 add: cmd{0,3C00,4000}, FPU model done 4 cyc after reset -> rsp_result=4200, ofuf=0, timeout=0, rsp_opcode=0.
//  2 mul/div: {2,4000,4200} -> 4600; {3,4600,4000} -> 4200; fpu_x/y/opcode stable LAUNCH..RESP; fpu_reset high exactly 1 cycle.
//  3 fill: 5 cmds back-to-back with DEPTH=4, rsp_ready=0 -> cmd_ready=0 after 4th held entry; all 5 answered in order.
//  4 backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_* held constant; no new LAUNCH until accepted.
//  5 timeout: FPU model never asserts done -> rsp at TIMEOUT cycles after WAIT entry, rsp_result=7E00, rsp_timeout=1; next cmd normal.
//  6 reset mid-WAIT with 2 queued -> rsp_valid=0, cmd_ready=1, fpu_reset=1 during reset, no stale response after release.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
//   Front end for a half-precision FPU. Commands ({opcode,x,y}) are queued in a
//   small FIFO and issued one at a time: the operands are parked on fpu_* and
//   the FPU gets a one-cycle reset pulse. The sequencer then waits for fpu_done,
//   or gives up after TIMEOUT cycles. The result is returned on a valid/ready
//   response port. Only one command is in flight, so responses come back in
//   command order.
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   cmd_valid/ready/opcode/x/y      command push side (ready = FIFO not full)
//   rsp_valid/ready                 response handshake; rsp_* held until taken
//   rsp_result/ofuf/opcode/timeout  answer of the oldest command
//   fpu_opcode/x/y/reset            drive side of the FPU
//   fpu_done/result/ofuf            FPU completion side
module fpu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_opcode,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_ofuf,
  output logic [1:0]  rsp_opcode,
  output logic        rsp_timeout,
  output logic [1:0]  fpu_opcode,
  output logic [15:0] fpu_x,
  output logic [15:0] fpu_y,
  output logic        fpu_reset,
  input  logic        fpu_done,
  input  logic [15:0] fpu_result,
  input  logic [1:0]  fpu_ofuf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [15:0]   QNAN     = 16'h7E00;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  // ---------------- command FIFO ----------------
  logic [33:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          push, pop;

  // ---------------- sequencer state ----------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fpu_opcode_q, fpu_opcode_d;
  logic [15:0]   fpu_x_q, fpu_x_d, fpu_y_q, fpu_y_d;
  logic [15:0]   rsp_result_q, rsp_result_d;
  logic [1:0]    rsp_ofuf_q, rsp_ofuf_d;
  logic [1:0]    rsp_opcode_q, rsp_opcode_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  // A full FIFO refuses a push even when it pops the same cycle, so ready
  // depends only on the registered fill level.
  assign cmd_ready = (fill_q != FILL_MAX);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (fill_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // Storage needs no reset: only entries below the fill level are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_opcode, cmd_x, cmd_y};
  end

  // ---------------- FSM next state / datapath ----------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fpu_opcode_d  = fpu_opcode_q;
    fpu_x_d       = fpu_x_q;
    fpu_y_d       = fpu_y_q;
    rsp_result_d  = rsp_result_q;
    rsp_ofuf_d    = rsp_ofuf_q;
    rsp_opcode_d  = rsp_opcode_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          {fpu_opcode_d, fpu_x_d, fpu_y_d} = mem_q[rd_ptr_q];
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // fpu_reset is high this cycle; any done left over from the previous
        // command is ignored because done is only looked at in WAIT.
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (fpu_done) begin
          rsp_result_d  = fpu_result;
          rsp_ofuf_d    = fpu_ofuf;
          rsp_opcode_d  = fpu_opcode_q;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d  = QNAN;
          rsp_ofuf_d    = 2'b00;
          rsp_opcode_d  = fpu_opcode_q;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      fpu_opcode_q  <= '0;
      fpu_x_q       <= '0;
      fpu_y_q       <= '0;
      rsp_result_q  <= '0;
      rsp_ofuf_q    <= '0;
      rsp_opcode_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fpu_opcode_q  <= fpu_opcode_d;
      fpu_x_q       <= fpu_x_d;
      fpu_y_q       <= fpu_y_d;
      rsp_result_q  <= rsp_result_d;
      rsp_ofuf_q    <= rsp_ofuf_d;
      rsp_opcode_q  <= rsp_opcode_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_result  = rsp_result_q;
  assign rsp_ofuf    = rsp_ofuf_q;
  assign rsp_opcode  = rsp_opcode_q;
  assign rsp_timeout = rsp_timeout_q;
  assign fpu_opcode  = fpu_opcode_q;
  assign fpu_x       = fpu_x_q;
  assign fpu_y       = fpu_y_q;
  assign fpu_reset   = reset | (state_q == LAUNCH);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
`timescale 1ns/1ps
module tb_fpu_op_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int NVEC    = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_opcode;
  logic [15:0] cmd_x, cmd_y;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_ofuf, rsp_opcode;
  logic        rsp_timeout;
  logic [1:0]  fpu_opcode;
  logic [15:0] fpu_x, fpu_y;
  logic        fpu_reset;
  logic        fpu_done = 1'b0;
  logic [15:0] fpu_result = '0;
  logic [1:0]  fpu_ofuf = '0;

  fpu_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_ofuf(rsp_ofuf), .rsp_opcode(rsp_opcode), .rsp_timeout(rsp_timeout),
    .fpu_opcode(fpu_opcode), .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_reset(fpu_reset),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_ofuf(fpu_ofuf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors: operands, hand-computed half-precision answer, flags,
  // FPU delay (cycles of WAIT until done), and whether the FPU hangs.
  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] res;
    logic [1:0]  ofuf;
    logic [7:0]  dly;
    logic        never;
  } vec_t;

  function automatic vec_t vec(input int i);
    case (i)
      0: return vec_t'{2'd0, 16'h3C00, 16'h4000, 16'h4200, 2'b00, 8'd4, 1'b0}; // 1+2=3
      1: return vec_t'{2'd2, 16'h4000, 16'h4200, 16'h4600, 2'b00, 8'd3, 1'b0}; // 2*3=6
      2: return vec_t'{2'd3, 16'h4600, 16'h4000, 16'h4200, 2'b00, 8'd5, 1'b0}; // 6/2=3
      3: return vec_t'{2'd1, 16'h4200, 16'h3C00, 16'h4000, 2'b00, 8'd2, 1'b0}; // 3-1=2
      4: return vec_t'{2'd0, 16'h7BFF, 16'h7BFF, 16'h7C00, 2'b10, 8'd1, 1'b0}; // max+max overflow
      5: return vec_t'{2'd2, 16'h0400, 16'h0400, 16'h0000, 2'b01, 8'd1, 1'b0}; // min*min underflow
      6: return vec_t'{2'd3, 16'h3C00, 16'h0000, 16'h7C00, 2'b11, 8'd1, 1'b1}; // FPU hangs
      7: return vec_t'{2'd1, 16'h3C00, 16'h3C00, 16'h0000, 2'b00, 8'd2, 1'b0}; // 1-1=0
      8: return vec_t'{2'd3, 16'h4000, 16'h0000, 16'h7C00, 2'b11, 8'd1, 1'b1}; // FPU hangs
      default: return vec_t'{2'd0, 16'h0000, 16'h0000, 16'hDEAD, 2'b11, 8'd1, 1'b0};
    endcase
  endfunction

  function automatic vec_t lookup(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    for (int i = 0; i < NVEC; i++) begin
      if (vec(i).op == op && vec(i).x == x && vec(i).y == y) return vec(i);
    end
    return vec(-1);
  endfunction

  // FPU model: restarts on fpu_reset, raises done dly cycles later and keeps
  // it high (stale) until the next restart.
  vec_t mv;
  int   mcnt = 0;
  always_comb mv = lookup(fpu_opcode, fpu_x, fpu_y);
  always @(posedge clk) begin
    if (fpu_reset) begin
      mcnt     <= 0;
      fpu_done <= 1'b0;
    end else begin
      if (mcnt < 1000) mcnt <= mcnt + 1;
      fpu_done <= !mv.never && (mcnt + 1 >= int'(mv.dly));
    end
    fpu_result <= mv.res;
    fpu_ofuf   <= mv.ofuf;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  op;
    logic [15:0] x, y, res;
    logic [1:0]  ofuf;
    logic        tmo;
    int          lat;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;
  int last_push_cyc = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  logic        prev_v = 1'b0, prev_rdy = 1'b0, busy = 1'b0;
  logic [20:0] prev_data = '0;
  logic [33:0] snap = '0;
  int          rst_len = 0, launch_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_v   <= 1'b0;
      prev_rdy <= 1'b0;
      rst_len  <= 0;
      busy     <= 1'b0;
    end else begin
      if (fpu_reset) begin
        if (rst_len == 0) begin
          launch_cyc <= cyc;
          snap       <= {fpu_opcode, fpu_x, fpu_y};
        end
        rst_len <= rst_len + 1;
        busy    <= 1'b1;
      end else begin
        if (rst_len != 0) chk("fpu_reset_pulse_len", 64'(rst_len), 64'd1);
        rst_len <= 0;
        if (busy) chk("fpu_ops_stable", {30'd0, fpu_opcode, fpu_x, fpu_y}, {30'd0, snap});
      end
      if (rsp_valid) chk("no_launch_while_rsp", 64'(fpu_reset), 64'd0);
      if (rsp_valid && !prev_v) begin
        if (q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
        else chk("rsp_latency_from_launch", 64'(cyc - launch_cyc), 64'(q[0].lat));
      end
      if (prev_v && !prev_rdy) begin
        chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_hold_data", 64'({rsp_result, rsp_ofuf, rsp_opcode, rsp_timeout}), 64'(prev_data));
      end
      if (rsp_valid && rsp_ready && q.size() != 0) begin
        chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
        chk("rsp_ofuf", 64'(rsp_ofuf), 64'(q[0].ofuf));
        chk("rsp_opcode", 64'(rsp_opcode), 64'(q[0].op));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(q[0].tmo));
        chk("fpu_operands", {30'd0, fpu_opcode, fpu_x, fpu_y}, {30'd0, q[0].op, q[0].x, q[0].y});
        q.delete(0);
      end
      if (rsp_valid && rsp_ready) busy <= 1'b0;
      prev_v    <= rsp_valid;
      prev_rdy  <= rsp_ready;
      prev_data <= {rsp_result, rsp_ofuf, rsp_opcode, rsp_timeout};
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a posedge; returns just after the posedge that pushed.
  task automatic send(input int i);
    vec_t v = vec(i);
    exp_t e;
    int   n = 0;
    cmd_valid = 1'b1; cmd_opcode = v.op; cmd_x = v.x; cmd_y = v.y;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (cmd_ready) begin
      e.op = v.op; e.x = v.x; e.y = v.y;
      e.res  = v.never ? 16'h7E00 : v.res;
      e.ofuf = v.never ? 2'b00 : v.ofuf;
      e.tmo  = v.never;
      e.lat  = v.never ? TIMEOUT + 1 : int'(v.dly) + 2;
      q.push_back(e);
      last_push_cyc = cyc;
    end else begin
      chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 2000) begin @(posedge clk); n++; end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_x = '0; cmd_y = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_fields", 64'({rsp_result, rsp_ofuf, rsp_opcode, rsp_timeout}), 64'd0);
    chk("rst_fpu_ops", 64'({fpu_opcode, fpu_x, fpu_y}), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_fpu_reset", 64'(fpu_reset), 64'd1);
    @(posedge clk); #1 reset = 1'b0;

    // single add into an empty FIFO, check issue latency
    send(0);
    drain();
    chk("push_to_launch", 64'(launch_cyc - last_push_cyc), 64'd2);

    // mul then div, back to back
    send(1); send(2);
    drain();

    // fill the FIFO while the response is stalled
    rsp_ready = 1'b0;
    send(3); send(4); send(5); send(7); send(0);
    repeat (12) @(negedge clk);
    chk("fifo_full_cmd_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_opcode = 2'd2; cmd_x = 16'h4000; cmd_y = 16'h4200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_refuses_push", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    // FPU hang -> timeout answer, then a normal command
    send(6); send(7);
    drain();

    // reset while waiting with two commands queued
    send(8); send(0); send(1);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst_fpu_reset", 64'(fpu_reset), 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    send(3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
